tim_arbiter: RTL

Two-requester arbiter that shares the single backing-memory port between the instruction tightly-integrated memory (itim) and the data one (dtim). It sits between the two TIM controllers' memory-side ports and the memory/bus interface. It latches one outstanding request per side and grants the port round-robin (or fixed data priority). It holds the grant until the memory returns `mem_ready` and forwards the response only to the owning side.

---
 rtl/tim_arbiter_pkg.sv | 66 ++++++
 rtl/tim_arbiter_buffer.sv | 38 +++
 rtl/tim_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/tim_arbiter_pkg.sv
// tim_arbiter_wires: shared types and constants for the itim/dtim memory-port
// arbiter.
//   mem_in_type      request record (controller memory side -> memory)
//   mem_out_type     response record (memory -> controller memory side)
//   arb_state_type   arbiter states IDLE / SERVE_I / SERVE_D
//   tim_arb_buf_type one-entry per-side request buffer
//   tim_arb_reg_type registered arbiter state (state + last served side)
package tim_arbiter_wires;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_fence;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_type;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_type;

  typedef struct packed {
    logic        full;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    logic        fence;
  } tim_arb_buf_type;

  typedef struct packed {
    arb_state_type state;
    side_type      last;
  } tim_arb_reg_type;

  localparam tim_arb_buf_type init_buf     = '0;
  localparam mem_in_type      init_mem_in  = '0;
  localparam mem_out_type     init_mem_out = '0;
  localparam tim_arb_reg_type init_reg     = '{state: IDLE, last: SIDE_I};

  // Present a buffered request on the memory port; valid mirrors occupancy.
  function automatic mem_in_type buf_to_req(input tim_arb_buf_type b);
    mem_in_type req;
    req.mem_valid = b.full;
    req.mem_instr = b.instr;
    req.mem_fence = b.fence;
    req.mem_addr  = b.addr;
    req.mem_wdata = b.wdata;
    req.mem_wstrb = b.wstrb;
    return req;
  endfunction

endpackage

// File: rtl/tim_arbiter_buffer.sv
// tim_arbiter_buffer: one-entry request holding register for one arbiter side.
//   clk    clock
//   rst    synchronous active-low reset (empties the buffer)
//   req    request from the controller memory side (valid held until ready)
//   clear  transaction for this side completed this cycle
//   buffer captured request with full flag
module tim_arbiter_buffer
  import tim_arbiter_wires::*;
(
  input  logic            clk,
  input  logic            rst,
  input  mem_in_type      req,
  input  logic            clear,
  output tim_arb_buf_type buffer
);

  tim_arb_buf_type b;

  // Clear wins over capture: the requester still holds valid for the request
  // being completed, so it must not be re-captured in its own ready cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      b <= init_buf;
    end else if (clear) begin
      b <= init_buf;
    end else if (req.mem_valid && !b.full) begin
      b.full  <= 1'b1;
      b.addr  <= req.mem_addr;
      b.wdata <= req.mem_wdata;
      b.wstrb <= req.mem_wstrb;
      b.instr <= req.mem_instr;
      b.fence <= req.mem_fence;
    end
  end

  assign buffer = b;

endmodule

// File: rtl/tim_arbiter.sv
// tim_arbiter: shares one backing-memory port between the itim and dtim
// controllers. One outstanding request is latched per side; the port is granted
// round-robin (or with fixed data priority) and held until mem_ready, whose
// response is forwarded combinationally to the owning side only.
//   fixed_prio  0: round-robin on ties, 1: data side wins ties
//   clk, rst    clock, synchronous active-low reset
//   imem_in     request from itim controller   imem_out  response to itim
//   dmem_in     request from dtim controller   dmem_out  response to dtim
//   mem_in      request to backing memory      mem_out   response from memory
module tim_arbiter
  import tim_arbiter_wires::*;
#(
  parameter bit fixed_prio = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  tim_arb_buf_type ibuf;
  tim_arb_buf_type dbuf;
  logic            clear_i;
  logic            clear_d;
  logic            pend_i;
  logic            pend_d;
  tim_arb_reg_type r;
  tim_arb_reg_type rin;

  tim_arbiter_buffer u_ibuf (
    .clk    (clk),
    .rst    (rst),
    .req    (imem_in),
    .clear  (clear_i),
    .buffer (ibuf)
  );

  tim_arbiter_buffer u_dbuf (
    .clk    (clk),
    .rst    (rst),
    .req    (dmem_in),
    .clear  (clear_d),
    .buffer (dbuf)
  );

  always_comb begin
    rin      = r;
    mem_in   = init_mem_in;
    imem_out = init_mem_out;
    dmem_out = init_mem_out;
    clear_i  = 1'b0;
    clear_d  = 1'b0;
    // IDLE looks at the incoming valid as well as the buffer: the buffer
    // captures at the same edge the state enters SERVE, so the request is
    // on the memory port one cycle after it is first seen.
    pend_i   = ibuf.full | imem_in.mem_valid;
    pend_d   = dbuf.full | dmem_in.mem_valid;

    case (r.state)
      IDLE: begin
        if (pend_i && pend_d) begin
          if (fixed_prio || r.last == SIDE_I) begin
            rin.state = SERVE_D;
          end else begin
            rin.state = SERVE_I;
          end
        end else if (pend_d) begin
          rin.state = SERVE_D;
        end else if (pend_i) begin
          rin.state = SERVE_I;
        end
      end

      SERVE_I: begin
        mem_in = buf_to_req(ibuf);
        if (mem_out.mem_ready) begin
          imem_out  = mem_out;
          clear_i   = 1'b1;
          rin.last  = SIDE_I;
          rin.state = dbuf.full ? SERVE_D : IDLE;
        end
      end

      SERVE_D: begin
        mem_in = buf_to_req(dbuf);
        if (mem_out.mem_ready) begin
          dmem_out  = mem_out;
          clear_d   = 1'b1;
          rin.last  = SIDE_D;
          rin.state = ibuf.full ? SERVE_I : IDLE;
        end
      end

      default: begin
        rin.state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r <= init_reg;
    end else begin
      r <= rin;
    end
  end

endmodule
